shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 128 ++++++++++++
 tb/tb_shift_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Sequencer for an external 4-bit universal shift register. It issues
// parallel-load and direction controls and keeps a shadow copy of the
// register contents in `result`.
//
// state | meaning
// IDLE  | waiting for start; register held via parallel load of result
// LOAD  | parallel-load the latched data_in into the register
// SHIFT | one rotate/shift step per cycle until the step counter expires
// DONE  | one-cycle completion pulse, register held
module shift_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] count,
  input  logic [3:0] data_in,
  input  logic       abort,
  output logic       load_n,
  output logic       rotate_right,
  output logic       as_right,
  output logic [3:0] data_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_ROL = 2'd0;
  localparam logic [1:0] OP_ROR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  logic [1:0] state;
  logic [1:0] op_q;
  logic [3:0] count_q;
  logic [3:0] data_q;
  logic [3:0] steps;
  logic [3:0] shifted;

  // Next shadow value for one step of the latched operation.
  always_comb begin
    shifted = result;
    case (op_q)
      OP_ROL:  shifted = {result[2:0], result[3]};
      OP_ROR:  shifted = {result[0], result[3:1]};
      OP_ASR:  shifted = {result[3], result[3:1]};
      default: shifted = result;
    endcase
  end

  // Control state, latched request, step counter and shadow register.
  // An abort in LOAD/SHIFT still lets that cycle's register action land in
  // the shadow, since the external register performs it on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= 2'd0;
      count_q <= 4'd0;
      data_q  <= 4'd0;
      steps   <= 4'd0;
      result  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            op_q    <= op;
            count_q <= count;
            data_q  <= data_in;
            state   <= LOAD;
          end
        end
        LOAD: begin
          result <= data_q;
          if (abort) begin
            state <= IDLE;
          end else if (count_q == 4'd0 || op_q == OP_RSV) begin
            state <= DONE;
          end else begin
            steps <= count_q;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          result <= shifted;
          steps  <= steps - 4'd1;
          if (abort) begin
            state <= IDLE;
          end else if (steps == 4'd1) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Register control outputs decoded from the current state.
  always_comb begin
    load_n       = 1'b0;
    rotate_right = 1'b0;
    as_right     = 1'b0;
    data_out     = result;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      LOAD: begin
        data_out = data_q;
      end
      SHIFT: begin
        load_n       = 1'b1;
        rotate_right = (op_q == OP_ROR) || (op_q == OP_ASR);
        as_right     = (op_q == OP_ASR);
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a timeline model (cycle offset since the
// accepted start) predicts every output each cycle, and directed operations
// pin latency and final results against hand-computed values.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [3:0] count;
  logic [3:0] data_in;
  logic       abort;
  logic       load_n;
  logic       rotate_right;
  logic       as_right;
  logic [3:0] data_out;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .count(count),
    .data_in(data_in), .abort(abort), .load_n(load_n),
    .rotate_right(rotate_right), .as_right(as_right), .data_out(data_out),
    .busy(busy), .done(done), .result(result)
  );

  // 10 ns clock period.
  always #5 clock = ~clock;

  // ---------------- model ----------------
  bit       m_valid = 0;
  bit       m_active = 0;
  int       m_k = 0;
  int       m_n = 0;
  int       m_op = 0;
  int       m_data = 0;
  int       m_res = 0;

  function automatic int step_val(int r, int o);
    int s;
    case (o)
      0: s = ((r * 2) + (r / 8)) % 16;
      1: s = (r / 2) + ((r % 2) * 8);
      2: s = (r / 2) + ((r >= 8) ? 8 : 0);
      default: s = r;
    endcase
    return s;
  endfunction

  // phase: 0 idle, 1 load, 2 shift, 3 done
  function automatic int phase();
    if (!m_active) return 0;
    if (m_k == 1) return 1;
    if (m_k <= 1 + m_n) return 2;
    return 3;
  endfunction

  // Model advances on each rising edge from the inputs held before it.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_valid = 1; m_active = 0; m_res = 0;
      end else if (m_valid) begin
        case (phase())
          0: if (start && !abort) begin
               m_active = 1; m_k = 1; m_op = op; m_data = data_in;
               m_n = (op == 2'd3) ? 0 : int'(count);
             end
          1: begin m_res = m_data; if (abort) m_active = 0; else m_k++; end
          2: begin m_res = step_val(m_res, m_op); if (abort) m_active = 0; else m_k++; end
          default: m_active = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic [12:0] act, exp_v, mask;
    int ph;
    forever begin
      @(negedge clock);
      if (m_valid) begin
        ph = phase();
        act = {load_n, rotate_right, as_right, busy, done, result, data_out};
        mask = 13'h1fff;
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(m_res), 4'(m_res)};
        case (ph)
          1: exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(m_res), 4'(m_data)};
          2: begin
               exp_v = {1'b1, (m_op == 1 || m_op == 2), (m_op == 2), 1'b1, 1'b0,
                        4'(m_res), 4'd0};
               mask = 13'h1ff0;
             end
          3: exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'(m_res), 4'(m_res)};
          default: ;
        endcase
        checks++;
        if ((act & mask) != (exp_v & mask)) begin
          errors++;
          $display("FAIL model_cycle t=%0t phase=%0d got=%b expected=%b (ld_n rr asr busy done result data_out)",
                   $time, ph, act, exp_v);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input logic s, input logic a);
    start = s; abort = a;
    @(posedge clock); #1;
  endtask

  // Pulse start in IDLE, wait (bounded) for done, check latency/result,
  // then step into the following IDLE cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [3:0] c,
                        input logic [3:0] d, input int exp_res, input int exp_lat,
                        input int exp_asr);
    int edges = 0;
    int asr_cyc = 0;
    bit got = 0;
    op = o; count = c; data_in = d; start = 1'b1; abort = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clock); #1;
      start = 1'b0;
      edges++;
      if (as_right && rotate_right) asr_cyc++;
      if (done) got = 1;
    end
    chk({name, "_latency"}, got ? edges : -1, exp_lat);
    chk({name, "_result"}, int'(result), exp_res);
    if (exp_asr >= 0) chk({name, "_asr_cycles"}, asr_cyc, exp_asr);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0; count = 4'd0; data_in = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_load_n", int'(load_n), 0);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_dir", int'({rotate_right, as_right, done}), 0);
    reset = 1'b0;
    tick(0, 0);

    run_op("ror_1001_c1", 2'd1, 4'd1,  4'b1001, 4'b1100, 3, -1);
    run_op("rol_1001_c2", 2'd0, 4'd2,  4'b1001, 4'b0110, 4, -1);
    run_op("asr_1000_c3", 2'd2, 4'd3,  4'b1000, 4'b1111, 5, 3);
    run_op("ror_1011_c4", 2'd1, 4'd4,  4'b1011, 4'b1011, 6, -1);
    run_op("ror_0101_c0", 2'd1, 4'd0,  4'b0101, 4'b0101, 2, -1);
    run_op("rsv_0011_c5", 2'd3, 4'd5,  4'b0011, 4'b0011, 2, 0);
    run_op("rol_0001_c15", 2'd0, 4'd15, 4'b0001, 4'b1000, 17, -1);
    run_op("asr_0111_c15", 2'd2, 4'd15, 4'b0111, 4'b0000, 17, 15);

    // start during SHIFT ignored, abort in second SHIFT cycle
    op = 2'd1; count = 4'd3; data_in = 4'b1001;
    tick(1, 0);
    tick(0, 0);
    op = 2'd0; data_in = 4'b1111;
    tick(1, 0);
    tick(0, 1);
    chk("abort_shift_busy", int'(busy), 0);
    chk("abort_shift_result", int'(result), 4'b0110);
    tick(0, 0);
    tick(0, 0);
    chk("abort_no_requeue_busy", int'(busy), 0);
    chk("abort_no_done", int'(done), 0);

    // abort in LOAD
    op = 2'd1; count = 4'd2; data_in = 4'b0011;
    tick(1, 0);
    tick(0, 1);
    chk("abort_load_busy", int'(busy), 0);

    // abort and start together in IDLE
    tick(1, 1);
    chk("abort_start_idle_busy", int'(busy), 0);
    tick(0, 0);

    // abort in DONE does not suppress the pulse
    op = 2'd1; count = 4'd1; data_in = 4'b0001;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    chk("abort_done_pulse", int'(done), 1);
    tick(0, 1);
    chk("abort_done_result", int'(result), 4'b1000);
    chk("abort_done_idle", int'({busy, done}), 0);

    // reset mid-SHIFT
    op = 2'd0; count = 4'd5; data_in = 4'b0110;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    tick(1, 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_result", int'(result), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_data_out", int'({load_n, data_out}), 0);
    reset = 1'b0;
    tick(0, 0);

    run_op("recover_ror_0110_c2", 2'd1, 4'd2, 4'b0110, 4'b1001, 4, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
